if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage, directly upstream of the decode stage (ID) in the pipelined LoongArch CPU.
- Owns the PC and drives the synchronous instruction SRAM, which has one-cycle read latency.
- Hands {pc, inst} to ID with a valid/allowin handshake.
- Accepts branch redirects resolved in ID and cancels the wrong-path instruction.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ds_allowin  in  1  ID can accept an instruction this cycle
- br_taken  in  1  redirect request from ID; one-cycle pulse, already qualified by ID valid
- br_target  in  32  redirect address
- inst_sram_en  out  1  SRAM read request
- inst_sram_we  out  4  tied to 0
- inst_sram_addr  out  32  fetch address (nextpc)
- inst_sram_wdata  out  32  tied to 0
- inst_sram_rdata  in  32  data for the address requested the previous cycle
- fs_to_ds_valid  out  1  IF holds a valid, non-cancelled instruction for ID
- fs_to_ds_pc  out  32  PC of the offered instruction
- fs_to_ds_inst  out  32  offered instruction word

Behaviour:

State registers:
- fs_valid
- fs_pc
- br_pending, br_pending_target
- inst_buf, inst_buf_valid

Reset:
- fs_valid=0, fs_pc=RESET_PC-4, br_pending=0, inst_buf_valid=0, inst_buf=0.
- While reset is high: inst_sram_en=0 and fs_to_ds_valid=0.
- br_taken is ignored while reset is high.

Pre-IF (combinational):
- seq_pc = fs_pc + 4 (32-bit wrap).
- nextpc selection, in priority order:
  - br_taken -> br_target
  - br_pending -> br_pending_target
  - otherwise -> seq_pc
- fs_ready_go = 1.
- fs_allowin = ~fs_valid | ds_allowin.
- inst_sram_en = ~reset & fs_allowin.
- inst_sram_addr = nextpc.

Handshake:
- fs_to_ds_valid = fs_valid & ~br_taken.
  - A branch pulse cancels the instruction currently in IF: it is the sequential successor of the branch, so it is wrong-path.
- A transfer to ID occurs on cycles where fs_to_ds_valid & ds_allowin.

Sequential update, when inst_sram_en=1:
- fs_valid<=1, fs_pc<=nextpc, br_pending<=0.
- The instruction appears on inst_sram_rdata in the next cycle.

Sequential update, when inst_sram_en=0:
- If br_taken: br_pending<=1, br_pending_target<=br_target, fs_valid<=0.
- Otherwise: fs_valid unchanged.
- If ID drains IF (fs_valid & ds_allowin), the en=1 path applies instead.

Instruction buffer (SRAM data is valid only in the cycle after a request):
- fs_to_ds_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
- Capture: if fs_valid & ~ds_allowin & ~inst_buf_valid & ~br_taken, then inst_buf<=inst_sram_rdata and inst_buf_valid<=1.
- Clear inst_buf_valid on any of: transfer to ID, br_taken, reset.
- fs_to_ds_pc = fs_pc.

Simultaneous events:
- br_taken while br_pending: the new br_target wins and overwrites br_pending_target.
- br_taken in the same cycle as a stall release: the fetch goes to br_target; nothing is delivered that cycle.
- Mid-operation reset: all state is discarded; the first post-reset fetch is at RESET_PC.

Latency:
- Reset deasserted at cycle N: en=1 and addr=RESET_PC in cycle N; fs_to_ds_valid=1 with pc=RESET_PC in cycle N+1.
- Throughput is one instruction per cycle when ds_allowin is held high.
- Redirect penalty is one bubble: br_taken in cycle T gives the target valid in IF in cycle T+1.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC
  - FS_TO_DS_BUS_WD=64
  - BR_BUS_WD=33, with br bus packing {taken, target}
  - SRAM_WE_WD=4
- One sub-module is natural: if_inst_buf, holding the buffer register, valid flag and output mux. PC and pre-IF logic stay in if_stage.

Test Plan:
- Reset release, ds_allowin=1 -> addr sequence 1c000000, 1c000004, 1c000008; fs_to_ds_pc follows one cycle later with valid=1 each cycle.
- ds_allowin=0 for 3 cycles while IF holds pc 1c000008 (rdata 0x02800421 in the first cycle, then garbage) -> en=0 and addr steady; on release, fs_to_ds_inst=0x02800421, and the next fetch address is 1c00000c.
- br_taken=1, br_target=1c000100 while IF holds 1c000004 -> fs_to_ds_valid=0 that cycle, addr=1c000100; next cycle pc=1c000100 is valid.
- br_taken=1, br_target=1c000200 while ds_allowin=0 and fs_valid=1 -> fs_valid cleared, br_pending set; when ds_allowin returns, addr=1c000200 and no wrong-path instruction is delivered.
- Two back-to-back br_taken pulses (targets 1c000300 then 1c000400) during a stall -> only 1c000400 is fetched.
- Reset asserted mid-stream with inst_buf_valid=1 -> fs_to_ds_valid=0 and en=0 during reset; after release, the first address is 1c000000 and stale buffer content never appears.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline stages.
// Holds the reset PC, bus widths and the IF->ID / branch bundles.
package cpu_pkg;

    localparam logic [31:0] RESET_PC        = 32'h1c000000;
    localparam int          FS_TO_DS_BUS_WD = 64;
    localparam int          BR_BUS_WD       = 33;
    localparam int          SRAM_WE_WD      = 4;

    // Branch bus packing: {taken, target}
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // IF -> ID bundle: {pc, inst}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_t;

endpackage

// File: rtl/if_stage_if.sv
// IF-stage bundle: ID handshake, branch redirect and instruction SRAM.
// master = fetch stage side, slave = ID/SRAM side.
interface if_stage_if;
    import cpu_pkg::*;

    logic                  ds_allowin;
    logic                  br_taken;
    logic [31:0]           br_target;
    logic                  inst_sram_en;
    logic [SRAM_WE_WD-1:0] inst_sram_we;
    logic [31:0]           inst_sram_addr;
    logic [31:0]           inst_sram_wdata;
    logic [31:0]           inst_sram_rdata;
    logic                  fs_to_ds_valid;
    logic [31:0]           fs_to_ds_pc;
    logic [31:0]           fs_to_ds_inst;

    modport master (
        input  ds_allowin, br_taken, br_target, inst_sram_rdata,
        output inst_sram_en, inst_sram_we, inst_sram_addr,
        output inst_sram_wdata, fs_to_ds_valid, fs_to_ds_pc,
        output fs_to_ds_inst
    );

    modport slave (
        output ds_allowin, br_taken, br_target, inst_sram_rdata,
        input  inst_sram_en, inst_sram_we, inst_sram_addr,
        input  inst_sram_wdata, fs_to_ds_valid, fs_to_ds_pc,
        input  fs_to_ds_inst
    );

endinterface

// File: rtl/if_inst_buf.sv
// Holds the SRAM word while ID stalls, since rdata is valid one cycle only.
// Ports: clk/reset, fs_valid, ds_allowin, br_taken, rdata in; inst out.
module if_inst_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_valid,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] rdata,
    output logic [31:0] inst
);

    logic [31:0] inst_buf;
    logic        inst_buf_valid;
    logic        xfer;

    assign xfer = fs_valid & ~br_taken & ds_allowin;
    assign inst = inst_buf_valid ? inst_buf : rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_buf       <= '0;
            inst_buf_valid <= 1'b0;
        end else if (br_taken | xfer) begin
            inst_buf_valid <= 1'b0;
        end else if (fs_valid & ~ds_allowin & ~inst_buf_valid) begin
            inst_buf       <= rdata;
            inst_buf_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction SRAM.
// Ports: clk, reset, bus (if_stage_if.master: ID handshake, redirect, SRAM).
module if_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);
    import cpu_pkg::*;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        br_pending;
    logic [31:0] br_pending_target;

    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        fs_en;
    logic [31:0] fs_inst;
    br_bus_t     br_bus;
    fs_to_ds_t   fs_to_ds_bus;

    assign br_bus      = '{taken: bus.br_taken, target: bus.br_target};
    assign seq_pc      = fs_pc + 32'd4;
    assign fs_ready_go = 1'b1;
    assign fs_allowin  = ~fs_valid | (fs_ready_go & bus.ds_allowin);
    assign fs_en       = ~reset & fs_allowin;

    always_comb begin
        nextpc = seq_pc;
        if (br_bus.taken)
            nextpc = br_bus.target;
        else if (br_pending)
            nextpc = br_pending_target;
    end

    // The instruction in IF is the branch's fall-through: drop it.
    assign bus.fs_to_ds_valid = fs_valid & fs_ready_go
                              & ~br_bus.taken & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid          <= 1'b0;
            fs_pc             <= RESET_PC - 32'd4;
            br_pending        <= 1'b0;
            br_pending_target <= '0;
        end else if (fs_en) begin
            fs_valid   <= 1'b1;
            fs_pc      <= nextpc;
            br_pending <= 1'b0;
        end else if (br_bus.taken) begin
            // Can't fetch now: remember the target for the next slot.
            br_pending        <= 1'b1;
            br_pending_target <= br_bus.target;
            fs_valid          <= 1'b0;
        end
    end

    if_inst_buf u_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .fs_valid  (fs_valid),
        .ds_allowin(bus.ds_allowin),
        .br_taken  (br_bus.taken),
        .rdata     (bus.inst_sram_rdata),
        .inst      (fs_inst)
    );

    assign fs_to_ds_bus = '{pc: fs_pc, inst: fs_inst};

    assign bus.fs_to_ds_pc     = fs_to_ds_bus.pc;
    assign bus.fs_to_ds_inst   = fs_to_ds_bus.inst;
    assign bus.inst_sram_en    = fs_en;
    assign bus.inst_sram_we    = '0;
    assign bus.inst_sram_addr  = nextpc;
    assign bus.inst_sram_wdata = '0;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table plus randomized run
// checked against a fetch/delivery stream model.
module tb_if_stage;
    import cpu_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h1c000008)
            return 32'h02800421;
        return (a * 32'h9e3779b1) ^ 32'h5a5a5a5a;
    endfunction

    // One-cycle-latency SRAM; unrequested cycles return garbage.
    always @(posedge clk)
        bus.inst_sram_rdata <= bus.inst_sram_en
                               ? mem(bus.inst_sram_addr) : $urandom;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        alw;
        logic        br;
        logic [31:0] tgt;
        logic        en;
        logic        ca;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t v(
        input logic rst, input logic alw, input logic br,
        input logic [31:0] tgt, input logic en, input logic ca,
        input logic [31:0] addr, input logic vld,
        input logic [31:0] pc);
        vec_t r;
        r.rst = rst; r.alw = alw; r.br = br; r.tgt = tgt;
        r.en = en; r.ca = ca; r.addr = addr; r.vld = vld; r.pc = pc;
        return r;
    endfunction

    vec_t tab[31];

    initial begin
        logic [31:0] exp_fetch;
        logic [31:0] exp_deliv;
        logic [31:0] ea;
        logic        prev_ok;
        logic        prev_alw;
        logic        rst;
        logic        alw;
        logic        br;
        logic [31:0] tgt;
        int          deliv;

        total = 0;
        bad   = 0;

        tab[0]  = v(1,1,0,0,            0,0,0,            0,0);
        tab[1]  = v(0,1,0,0,            1,1,32'h1c000000, 0,0);
        tab[2]  = v(0,1,0,0,            1,1,32'h1c000004, 1,32'h1c000000);
        tab[3]  = v(0,1,0,0,            1,1,32'h1c000008, 1,32'h1c000004);
        tab[4]  = v(0,0,0,0,            0,1,32'h1c00000c, 1,32'h1c000008);
        tab[5]  = v(0,0,0,0,            0,1,32'h1c00000c, 1,32'h1c000008);
        tab[6]  = v(0,0,0,0,            0,1,32'h1c00000c, 1,32'h1c000008);
        tab[7]  = v(0,1,0,0,            1,1,32'h1c00000c, 1,32'h1c000008);
        tab[8]  = v(0,1,0,0,            1,1,32'h1c000010, 1,32'h1c00000c);
        tab[9]  = v(0,0,0,0,            0,1,32'h1c000014, 1,32'h1c000010);
        tab[10] = v(0,0,0,0,            0,1,32'h1c000014, 1,32'h1c000010);
        tab[11] = v(1,0,0,0,            0,0,0,            0,0);
        tab[12] = v(1,1,0,0,            0,0,0,            0,0);
        tab[13] = v(0,1,0,0,            1,1,32'h1c000000, 0,0);
        tab[14] = v(0,1,0,0,            1,1,32'h1c000004, 1,32'h1c000000);
        tab[15] = v(0,1,1,32'h1c000100, 1,1,32'h1c000100, 0,0);
        tab[16] = v(0,1,0,0,            1,1,32'h1c000104, 1,32'h1c000100);
        tab[17] = v(0,0,0,0,            0,1,32'h1c000108, 1,32'h1c000104);
        tab[18] = v(0,0,1,32'h1c000200, 0,1,32'h1c000200, 0,0);
        tab[19] = v(0,0,0,0,            1,1,32'h1c000200, 0,0);
        tab[20] = v(0,0,0,0,            0,1,32'h1c000204, 1,32'h1c000200);
        tab[21] = v(0,1,0,0,            1,1,32'h1c000204, 1,32'h1c000200);
        tab[22] = v(0,0,0,0,            0,1,32'h1c000208, 1,32'h1c000204);
        tab[23] = v(0,0,1,32'h1c000300, 0,1,32'h1c000300, 0,0);
        tab[24] = v(0,0,1,32'h1c000400, 1,1,32'h1c000400, 0,0);
        tab[25] = v(0,0,0,0,            0,1,32'h1c000404, 1,32'h1c000400);
        tab[26] = v(0,1,0,0,            1,1,32'h1c000404, 1,32'h1c000400);
        tab[27] = v(0,1,0,0,            1,1,32'h1c000408, 1,32'h1c000404);
        tab[28] = v(0,0,0,0,            0,1,32'h1c00040c, 1,32'h1c000408);
        tab[29] = v(0,1,1,32'h1c000500, 1,1,32'h1c000500, 0,0);
        tab[30] = v(0,1,0,0,            1,1,32'h1c000504, 1,32'h1c000500);

        reset          = 1'b1;
        bus.ds_allowin = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 31; i++) begin
            @(posedge clk);
            #1;
            reset          = tab[i].rst;
            bus.ds_allowin = tab[i].alw;
            bus.br_taken   = tab[i].br;
            bus.br_target  = tab[i].tgt;
            @(negedge clk);
            chk($sformatf("row%0d en", i),
                32'(bus.inst_sram_en), 32'(tab[i].en));
            chk($sformatf("row%0d valid", i),
                32'(bus.fs_to_ds_valid), 32'(tab[i].vld));
            if (tab[i].ca)
                chk($sformatf("row%0d addr", i),
                    bus.inst_sram_addr, tab[i].addr);
            if (tab[i].vld) begin
                chk($sformatf("row%0d pc", i),
                    bus.fs_to_ds_pc, tab[i].pc);
                chk($sformatf("row%0d inst", i),
                    bus.fs_to_ds_inst, mem(tab[i].pc));
            end
            if (i == 3) begin
                chk("we_zero", 32'(bus.inst_sram_we), 32'h0);
                chk("wdata_zero", bus.inst_sram_wdata, 32'h0);
            end
        end

        // Randomized run: fetch addresses and delivered PCs must each
        // follow pc+4 unless redirected, where the latest target wins.
        exp_fetch = RESET_PC;
        exp_deliv = RESET_PC;
        prev_ok   = 1'b0;
        prev_alw  = 1'b0;
        deliv     = 0;
        for (int c = 0; c < 1500; c++) begin
            rst = (c < 2) || ($urandom_range(0, 199) == 0);
            alw = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 99) < 12);
            tgt = 32'h1c000000 + (32'($urandom_range(0, 4095)) << 2);
            @(posedge clk);
            #1;
            reset          = rst;
            bus.ds_allowin = alw;
            bus.br_taken   = br;
            bus.br_target  = tgt;
            @(negedge clk);
            if (rst) begin
                chk("rnd rst en", 32'(bus.inst_sram_en), 32'h0);
                chk("rnd rst valid", 32'(bus.fs_to_ds_valid), 32'h0);
                exp_fetch = RESET_PC;
                exp_deliv = RESET_PC;
                prev_ok   = 1'b0;
                continue;
            end
            if (br)
                chk("rnd br cancels", 32'(bus.fs_to_ds_valid), 32'h0);
            if (alw)
                chk("rnd en on allowin", 32'(bus.inst_sram_en), 32'h1);
            if (prev_ok && prev_alw) begin
                chk("rnd occupied valid",
                    32'(bus.fs_to_ds_valid), 32'(!br));
                if (!alw)
                    chk("rnd stall en", 32'(bus.inst_sram_en), 32'h0);
            end
            if (bus.inst_sram_en) begin
                ea = br ? tgt : exp_fetch;
                chk("rnd fetch addr", bus.inst_sram_addr, ea);
                exp_fetch = ea + 32'd4;
            end else if (br) begin
                exp_fetch = tgt;
            end
            if (bus.fs_to_ds_valid) begin
                chk("rnd pc", bus.fs_to_ds_pc, exp_deliv);
                chk("rnd inst", bus.fs_to_ds_inst, mem(exp_deliv));
                if (alw) begin
                    exp_deliv = exp_deliv + 32'd4;
                    deliv++;
                end
            end
            if (br)
                exp_deliv = tgt;
            prev_alw = alw;
            prev_ok  = 1'b1;
        end
        chk("rnd throughput", 32'(deliv > 300), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
